// File: rtl/pwm_wb_sequencer.sv
// Table-driven PWM duty sequencer: a Wishbone write master that streams duty/hold entries to PWM channel registers.
// One write in flight at a time, each held until i_wb_ack; PWMSEQ_ACK_TIMEOUT_EN adds an ACK_TIMEOUT abort.
module pwm_wb_sequencer #(
  parameter int          DEPTH       = 8,
  parameter logic [15:0] CTRL_INIT   = 16'h0016,
  parameter int          ACK_TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ld_we,
  input  logic [3:0]  i_ld_idx,
  input  logic [1:0]  i_ld_ch,
  input  logic [15:0] i_ld_dc,
  input  logic [15:0] i_ld_hold,
  input  logic [4:0]  i_len,
  input  logic        i_loop,
  input  logic        i_start,
  input  logic        i_stop,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [15:0] o_wb_adr,
  output logic [15:0] o_wb_data,
  input  logic        i_wb_ack,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [3:0]  o_idx
);

  typedef enum logic [2:0] {IDLE, INIT_WR, STEP_WR, HOLD, STOP_WR} state_t;

  state_t      state;
  logic [1:0]  tbl_ch   [16];
  logic [15:0] tbl_dc   [16];
  logic [15:0] tbl_hold [16];
  logic [4:0]  len_q;
  logic        loop_q;
  logic [15:0] hold_cnt;
  logic        stop_pend;
  logic        stop_now;
  logic [4:0]  len_clamp;
  logic [4:0]  idx_next;
  logic [15:0] step_adr;

`ifdef PWMSEQ_ACK_TIMEOUT_EN
  logic [15:0] wt_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^ACK_TIMEOUT;
`endif

  assign o_busy    = (state != IDLE);
  assign stop_now  = stop_pend | i_stop;
  assign len_clamp = (i_len > 5'(DEPTH)) ? 5'(DEPTH) : i_len;
  assign idx_next  = {1'b0, o_idx} + 5'd1;
  assign step_adr  = 16'd6 + {12'd0, tbl_ch[o_idx], 2'b00};

  // Table storage is deliberately outside the reset domain so a reset keeps the loaded sequence.
  always_ff @(posedge i_clk) begin
    if (i_ld_we && state == IDLE && int'({28'd0, i_ld_idx}) < DEPTH) begin
      tbl_ch[i_ld_idx]   <= i_ld_ch;
      tbl_dc[i_ld_idx]   <= i_ld_dc;
      tbl_hold[i_ld_idx] <= i_ld_hold;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      o_wb_cyc  <= 1'b0;
      o_wb_stb  <= 1'b0;
      o_wb_we   <= 1'b0;
      o_wb_adr  <= 16'd0;
      o_wb_data <= 16'd0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
      o_idx     <= 4'd0;
      hold_cnt  <= 16'd0;
      stop_pend <= 1'b0;
      len_q     <= 5'd0;
      loop_q    <= 1'b0;
`ifdef PWMSEQ_ACK_TIMEOUT_EN
      wt_cnt    <= 16'd0;
`endif
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      if (i_stop && state != IDLE) stop_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (i_start && !i_stop) begin
            if (i_len == 5'd0) begin
              o_err <= 1'b1;
            end else begin
              len_q  <= len_clamp;
              loop_q <= i_loop;
              o_idx  <= 4'd0;
              state  <= INIT_WR;
            end
          end
        end

        // Each write state enters with strobes low, which guarantees the idle cycle between transactions.
        INIT_WR, STEP_WR, STOP_WR: begin
          if (!o_wb_cyc) begin
            o_wb_cyc <= 1'b1;
            o_wb_stb <= 1'b1;
            o_wb_we  <= 1'b1;
`ifdef PWMSEQ_ACK_TIMEOUT_EN
            wt_cnt   <= 16'd0;
`endif
            case (state)
              INIT_WR: begin
                o_wb_adr  <= 16'd0;
                o_wb_data <= CTRL_INIT;
              end
              STEP_WR: begin
                o_wb_adr  <= step_adr;
                o_wb_data <= tbl_dc[o_idx];
              end
              default: begin
                o_wb_adr  <= 16'd0;
                o_wb_data <= 16'd0;
              end
            endcase
          end else if (i_wb_ack) begin
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_wb_we  <= 1'b0;
            if (state == STOP_WR) begin
              o_done    <= 1'b1;
              stop_pend <= 1'b0;
              state     <= IDLE;
            end else if (stop_now) begin
              state <= STOP_WR;
            end else if (state == INIT_WR) begin
              state <= STEP_WR;
            end else begin
              hold_cnt <= tbl_hold[o_idx];
              state    <= HOLD;
            end
          end
`ifdef PWMSEQ_ACK_TIMEOUT_EN
          else if (wt_cnt == 16'(ACK_TIMEOUT - 1)) begin
            o_wb_cyc  <= 1'b0;
            o_wb_stb  <= 1'b0;
            o_wb_we   <= 1'b0;
            o_err     <= 1'b1;
            stop_pend <= 1'b0;
            state     <= IDLE;
          end else begin
            wt_cnt <= wt_cnt + 16'd1;
          end
`endif
        end

        // A hold of 0 or 1 both spend exactly one cycle here.
        HOLD: begin
          if (stop_now) begin
            state <= STOP_WR;
          end else if (hold_cnt <= 16'd1) begin
            hold_cnt <= 16'd0;
            if (idx_next < len_q) begin
              o_idx <= o_idx + 4'd1;
              state <= STEP_WR;
            end else if (loop_q) begin
              o_idx <= 4'd0;
              state <= STEP_WR;
            end else begin
              o_done <= 1'b1;
              state  <= IDLE;
            end
          end else begin
            hold_cnt <= hold_cnt - 16'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_wb_sequencer.sv
// Randomized bench for pwm_wb_sequencer: a Wishbone slave with programmable ack delay plus a table-level model of the expected write stream.
module tb_pwm_wb_sequencer;
  localparam int          DEPTH = 8;
  localparam logic [15:0] CTRL  = 16'h0016;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_we;
  logic [3:0]  ld_idx;
  logic [1:0]  ld_ch;
  logic [15:0] ld_dc;
  logic [15:0] ld_hold;
  logic [4:0]  len;
  logic        loop_f;
  logic        start;
  logic        stop;
  logic        wb_cyc, wb_stb, wb_we;
  logic [15:0] wb_adr, wb_data;
  logic        wb_ack;
  logic        busy, done, err;
  logic [3:0]  idx;

  pwm_wb_sequencer #(.DEPTH(DEPTH), .CTRL_INIT(CTRL), .ACK_TIMEOUT(15)) dut (
    .i_clk(clk), .i_rst(rst), .i_ld_we(ld_we), .i_ld_idx(ld_idx), .i_ld_ch(ld_ch),
    .i_ld_dc(ld_dc), .i_ld_hold(ld_hold), .i_len(len), .i_loop(loop_f),
    .i_start(start), .i_stop(stop), .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb),
    .o_wb_we(wb_we), .o_wb_adr(wb_adr), .o_wb_data(wb_data), .i_wb_ack(wb_ack),
    .o_busy(busy), .o_done(done), .o_err(err), .o_idx(idx)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_ch [16];
  int m_dc [16];
  int m_hold [16];
  logic [31:0] obs_wr[$];
  logic [31:0] exp_wr[$];
  int obs_gap[$];
  int exp_gap[$];
  int done_cnt = 0, err_cnt = 0, ack_dly = 1, wait_cnt = 0;
  int gap_cnt = 0, hi_cnt = 0, last_hi = 0, max_hi = 0, bad_bus = 0;
  logic prev_cyc = 1'b0;
  logic [15:0] first_adr = 16'd0, first_dat = 16'd0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  // Bus monitor and slave share one process so the ack decision and the recorded write stay ordered.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (wb_cyc !== wb_stb || wb_cyc !== wb_we) bad_bus++;
      if (wb_cyc) begin
        if (!prev_cyc) begin
          obs_gap.push_back(gap_cnt);
          first_adr = wb_adr;
          first_dat = wb_data;
          hi_cnt = 0;
        end else if (wb_adr !== first_adr || wb_data !== first_dat) begin
          bad_bus++;
        end
        hi_cnt++;
        if (hi_cnt > max_hi) max_hi = hi_cnt;
      end else begin
        if (prev_cyc) begin
          last_hi = hi_cnt;
          gap_cnt = 1;
        end else begin
          gap_cnt++;
        end
      end
      prev_cyc = wb_cyc;
      if (done) done_cnt++;
      if (err) err_cnt++;
    end else begin
      prev_cyc = 1'b0;
    end
    if (wb_ack) begin
      wb_ack = 1'b0;
      wait_cnt = 0;
    end else if (wb_cyc && !rst) begin
      if (wait_cnt >= ack_dly) begin
        wb_ack = 1'b1;
        obs_wr.push_back({wb_adr, wb_data});
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic load(input int i, input int ch, input int dc, input int hold, input bit model_upd);
    ld_we = 1'b1; ld_idx = 4'(i); ld_ch = 2'(ch); ld_dc = 16'(dc); ld_hold = 16'(hold);
    tick();
    ld_we = 1'b0;
    if (model_upd && i < DEPTH) begin
      m_ch[i] = ch; m_dc[i] = dc; m_hold[i] = hold;
    end
  endtask

  task automatic start_seq(input int l, input bit lp);
    len = 5'(l); loop_f = lp; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic clear_obs();
    obs_wr.delete();
    obs_gap.delete();
    max_hi = 0;
  endtask

  task automatic wait_end(input int d0, input int e0, input int budget, input string tag);
    int n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_finished"}, 32'(n < budget), 1);
  endtask

  task automatic wait_writes(input int k, input int budget, input string tag);
    int n = 0;
    while (obs_wr.size() < k && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_writes_seen"}, 32'(n < budget), 1);
  endtask

  // Expected write stream: Ctrl init, then each active entry per pass; gap = idle cycles before each write.
  function automatic void build_exp(input int l, input int passes);
    int n = (l > DEPTH) ? DEPTH : l;
    logic [15:0] a;
    exp_wr.delete();
    exp_gap.delete();
    exp_wr.push_back({16'd0, CTRL});
    exp_gap.push_back(0);
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < n; i++) begin
        int prev_h;
        a = 16'(6 + 4 * m_ch[i]);
        exp_wr.push_back({a, 16'(m_dc[i])});
        prev_h = m_hold[(i == 0) ? n - 1 : i - 1];
        exp_gap.push_back((p == 0 && i == 0) ? 1 : ((prev_h > 1) ? prev_h : 1) + 1);
      end
    end
  endfunction

  task automatic compare_run(input string tag, input int upto);
    int n = (upto < obs_wr.size()) ? upto : obs_wr.size();
    if (n > exp_wr.size()) n = exp_wr.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_wr"}, obs_wr[i], exp_wr[i]);
      if (i > 0 && i < obs_gap.size()) check({tag, "_gap"}, 32'(obs_gap[i]), 32'(exp_gap[i]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, e0, l, n;
    logic [31:0] last_wr;
    rst = 1'b1; ld_we = 1'b0; ld_idx = '0; ld_ch = '0; ld_dc = '0; ld_hold = '0;
    len = '0; loop_f = 1'b0; start = 1'b0; stop = 1'b0; wb_ack = 1'b0;
    repeat (3) tick();
    check("reset_ctl", {26'd0, wb_cyc, wb_stb, wb_we, busy, done, err}, 0);
    check("reset_bus", {wb_adr, wb_data}, 0);
    check("reset_idx", 32'(idx), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) load(i, $urandom_range(0, 3), $urandom_range(0, 65535), $urandom_range(0, 4), 1'b1);

    // Two-entry one-shot run; a start and a table write issued mid-run must both be ignored.
    load(0, 0, 100, 3, 1'b1);
    load(1, 2, 50, 0, 1'b1);
    ack_dly = 1; clear_obs(); d0 = done_cnt; e0 = err_cnt;
    start_seq(2, 1'b0);
    wait_writes(2, 100, "basic");
    start_seq(1, 1'b0);
    load(0, 3, 999, 7, 1'b0);
    wait_end(d0, e0, 200, "basic");
    build_exp(2, 1);
    check("basic_count", 32'(obs_wr.size()), 32'(exp_wr.size()));
    compare_run("basic", 99);
    check("basic_done", 32'(done_cnt - d0), 1);
    check("basic_err", 32'(err_cnt - e0), 0);
    check("basic_busy", 32'(busy), 0);

    // Looping run: no done while cycling, stop finishes with a Ctrl clear.
    clear_obs(); d0 = done_cnt;
    start_seq(2, 1'b1);
    wait_writes(6, 300, "loop");
    check("loop_no_done", 32'(done_cnt - d0), 0);
    build_exp(2, 3);
    compare_run("loop", 6);
    pulse_stop();
    wait_end(d0, err_cnt, 200, "loop");
    last_wr = (obs_wr.size() > 0) ? obs_wr[obs_wr.size() - 1] : 32'hffff_ffff;
    check("loop_stop_write", last_wr, 32'h0000_0000);
    check("loop_done", 32'(done_cnt - d0), 1);

    // Stop raised while the first duty write waits on a slow ack.
    ack_dly = 4; clear_obs(); d0 = done_cnt;
    start_seq(2, 1'b0);
    wait_writes(1, 100, "stop");
    tick();
    n = 0;
    while (!wb_cyc && n < 20) begin tick(); n++; end
    pulse_stop();
    wait_end(d0, err_cnt, 200, "stop");
    exp_wr = '{{16'd0, CTRL}, {16'd6, 16'd100}, 32'h0};
    exp_gap = '{0, 1, 1};
    check("stop_count", 32'(obs_wr.size()), 3);
    compare_run("stop", 3);
    check("stop_done", 32'(done_cnt - d0), 1);
    check("stop_ack_wait", 32'(max_hi), 5);
    tick();

`ifdef PWMSEQ_ACK_TIMEOUT_EN
    ack_dly = 100000; clear_obs(); d0 = done_cnt; e0 = err_cnt;
    start_seq(2, 1'b0);
    wait_end(d0, e0, 200, "timeout");
    check("timeout_err", 32'(err_cnt - e0), 1);
    check("timeout_done", 32'(done_cnt - d0), 0);
    check("timeout_strobe_len", 32'(last_hi), 15);
    check("timeout_busy", 32'(busy), 0);
    check("timeout_no_writes", 32'(obs_wr.size()), 0);
`else
    ack_dly = 40; clear_obs(); d0 = done_cnt; e0 = err_cnt;
    start_seq(2, 1'b0);
    wait_end(d0, e0, 500, "slow_ack");
    build_exp(2, 1);
    check("slow_ack_count", 32'(obs_wr.size()), 32'(exp_wr.size()));
    compare_run("slow_ack", 99);
    check("slow_ack_err", 32'(err_cnt - e0), 0);
    check("slow_ack_strobe_len", 32'(max_hi), 41);
`endif
    ack_dly = 1;
    repeat (3) tick();

    // Zero-length start errors; start together with stop does nothing.
    clear_obs(); e0 = err_cnt;
    start_seq(0, 1'b0);
    repeat (5) tick();
    check("len0_err", 32'(err_cnt - e0), 1);
    check("len0_no_bus", 32'(obs_gap.size()), 0);
    check("len0_busy", 32'(busy), 0);
    stop = 1'b1;
    start_seq(2, 1'b0);
    stop = 1'b0;
    repeat (5) tick();
    check("start_stop_idle", {31'd0, busy}, 0);
    check("start_stop_no_bus", 32'(obs_gap.size()), 0);

    // Reset in the middle of a long hold, then rerun the retained table.
    load(0, 1, 777, 20, 1'b1);
    clear_obs();
    start_seq(2, 1'b0);
    wait_writes(2, 100, "rst_mid");
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("rst_mid_ctl", {26'd0, wb_cyc, wb_stb, wb_we, busy, done, err}, 0);
    check("rst_mid_bus", {wb_adr, wb_data}, 0);
    check("rst_mid_idx", 32'(idx), 0);
    rst = 1'b0;
    tick();
    clear_obs(); d0 = done_cnt;
    start_seq(2, 1'b0);
    wait_end(d0, err_cnt, 300, "rerun");
    build_exp(2, 1);
    check("rerun_count", 32'(obs_wr.size()), 32'(exp_wr.size()));
    compare_run("rerun", 99);

    // Random tables, lengths (including above DEPTH) and ack delays.
    for (int r = 0; r < 5; r++) begin
      repeat (3) load($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 65535), $urandom_range(0, 4), 1'b1);
      l = $urandom_range(1, 20);
      ack_dly = $urandom_range(0, 3);
      clear_obs(); d0 = done_cnt;
      start_seq(l, 1'b0);
      wait_end(d0, err_cnt, 2000, "rand");
      build_exp(l, 1);
      check("rand_count", 32'(obs_wr.size()), 32'(exp_wr.size()));
      compare_run("rand", 99);
      check("rand_done", 32'(done_cnt - d0), 1);
      tick();
    end

    check("bus_protocol", 32'(bad_bus), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
